bp_mc_dram_word_bridge: RTL and testbench

Word-level bridge between a pumped BedRock memory-forward stream and the manycore DRAM (vcache) request network. Each forward beat becomes one manycore remote load or masked store. Returns may arrive out of order; a reorder buffer puts them back in order as BedRock reverse beats. This generalises the single-mode DRAM bridge in four ways: width-generic, byte-masked sub-word stores, sub-word load alignment, and credit-limited outstanding depth. It sits between the stream pumps and the manycore endpoint's out_request/in_response groups.

---
 rtl/bp_mc_dram_word_bridge_if.sv | 54 +++++
 rtl/bp_mc_dram_word_bridge.sv | 166 ++++++++++++++++
 tb/tb_bp_mc_dram_word_bridge.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_mc_dram_word_bridge_if.sv
// Bus bundle between the BedRock forward/reverse pumps, the manycore DRAM request/response ports and the word bridge.
// The slave modport is the bridge's side of the bus. The master modport is the environment's side.
interface bp_mc_dram_word_bridge_if #(
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 28,
    parameter int paddr_width_p  = 40,
    parameter int header_width_p = 64,
    parameter int outstanding_p  = 16
);
    localparam int tag_width_lp = $clog2(outstanding_p);

    logic [header_width_p-1:0] fwd_header_i;
    logic                      fwd_wr_i;
    logic [2:0]                fwd_size_i;
    logic [paddr_width_p-1:0]  fwd_addr_i;
    logic [data_width_p-1:0]   fwd_data_i;
    logic                      fwd_v_i;
    logic                      fwd_yumi_o;
    logic [addr_width_p-1:0]   dram_offset_i;

    logic                      req_v_o;
    logic                      req_ready_i;
    logic                      req_store_o;
    logic [addr_width_p-1:0]   req_addr_o;
    logic [data_width_p-1:0]   req_data_o;
    logic [data_width_p/8-1:0] req_mask_o;
    logic [tag_width_lp-1:0]   req_reg_id_o;

    logic                      resp_v_i;
    logic [tag_width_lp-1:0]   resp_reg_id_i;
    logic [data_width_p-1:0]   resp_data_i;

    logic [header_width_p-1:0] rev_header_o;
    logic [data_width_p-1:0]   rev_data_o;
    logic                      rev_v_o;
    logic                      rev_ready_and_i;

    logic                      idle_o;
    logic                      error_o;

    modport slave (
        input  fwd_header_i, fwd_wr_i, fwd_size_i, fwd_addr_i, fwd_data_i, fwd_v_i, dram_offset_i,
        input  req_ready_i, resp_v_i, resp_reg_id_i, resp_data_i, rev_ready_and_i,
        output fwd_yumi_o, req_v_o, req_store_o, req_addr_o, req_data_o, req_mask_o, req_reg_id_o,
        output rev_header_o, rev_data_o, rev_v_o, idle_o, error_o
    );

    modport master (
        output fwd_header_i, fwd_wr_i, fwd_size_i, fwd_addr_i, fwd_data_i, fwd_v_i, dram_offset_i,
        output req_ready_i, resp_v_i, resp_reg_id_i, resp_data_i, rev_ready_and_i,
        input  fwd_yumi_o, req_v_o, req_store_o, req_addr_o, req_data_o, req_mask_o, req_reg_id_o,
        input  rev_header_o, rev_data_o, rev_v_o, idle_o, error_o
    );
endinterface

// File: rtl/bp_mc_dram_word_bridge.sv
// Word bridge from the BedRock forward stream to manycore DRAM requests. A reorder buffer returns the responses in order.
// Defining BP_MC_DRAM_WORD_BRIDGE_TIMEOUT_EN builds the head-entry watchdog that drives error_o.
module bp_mc_dram_word_bridge #(
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 28,
    parameter int paddr_width_p  = 40,
    parameter int header_width_p = 64,
    parameter int outstanding_p  = 16,
    parameter int max_credits_p  = 8,
    parameter int timeout_p      = 4096
) (
    input logic                     clk_i,
    input logic                     reset_n_i,
    bp_mc_dram_word_bridge_if.slave bus
);
    localparam int bytes_lp        = data_width_p / 8;
    localparam int lg_bytes_lp     = $clog2(bytes_lp);
    localparam int tag_width_lp    = $clog2(outstanding_p);
    localparam int credit_width_lp = $clog2(max_credits_p + 1);

    typedef logic [tag_width_lp:0]   ptr_t;
    typedef logic [tag_width_lp-1:0] tag_t;
    typedef logic [data_width_p-1:0] word_t;

    typedef struct packed {
        logic [lg_bytes_lp-1:0] offset;
        logic [2:0]             size;
    } beat_info_t;

    // Sizes at or above the word size are treated as a full word.
    function automatic logic [bytes_lp-1:0] byte_mask(input logic [2:0] size,
                                                      input logic [lg_bytes_lp-1:0] offset);
        logic [bytes_lp-1:0] m;
        int n;
        m = '1;
        if (int'(size) < lg_bytes_lp) begin
            n = 1 << size;
            for (int i = 0; i < bytes_lp; i++)
                m[i] = (i >= int'(offset)) && (i < int'(offset) + n);
        end
        return m;
    endfunction

    function automatic word_t replicate(input word_t word, input logic [2:0] size);
        word_t r;
        int n;
        r = word;
        if (int'(size) < lg_bytes_lp) begin
            n = 1 << size;
            for (int i = 0; i < bytes_lp; i++)
                r[i*8 +: 8] = word[(i & (n - 1))*8 +: 8];
        end
        return r;
    endfunction

    ptr_t                       head_r, tail_r;
    tag_t                       head_idx, tail_idx;
    logic [credit_width_lp-1:0] credits_r;
    logic [outstanding_p-1:0]   alloc_r, valid_r;
    logic                       full, empty, yumi, resp_hit, deq;

    logic [header_width_p-1:0]  hdr_mem  [outstanding_p];
    beat_info_t                 info_mem [outstanding_p];
    word_t                      data_mem [outstanding_p];

    logic [paddr_width_p-1:0]   fwd_word_addr;
    logic [lg_bytes_lp-1:0]     fwd_offset;
    beat_info_t                 head_info;

    assign head_idx = head_r[tag_width_lp-1:0];
    assign tail_idx = tail_r[tag_width_lp-1:0];
    assign empty    = (head_r == tail_r);
    assign full     = (head_r[tag_width_lp] != tail_r[tag_width_lp]) && (head_idx == tail_idx);

    // The issue path is combinational, so a beat is accepted in the same cycle it is offered.
    assign bus.req_v_o    = bus.fwd_v_i & ~full & (credits_r != '0);
    assign yumi           = bus.req_v_o & bus.req_ready_i;
    assign bus.fwd_yumi_o = yumi;

    assign fwd_offset       = bus.fwd_addr_i[lg_bytes_lp-1:0];
    assign fwd_word_addr    = bus.fwd_addr_i >> lg_bytes_lp;
    assign bus.req_addr_o   = fwd_word_addr[addr_width_p-1:0] + bus.dram_offset_i;
    assign bus.req_store_o  = bus.fwd_wr_i;
    assign bus.req_mask_o   = bus.fwd_wr_i ? byte_mask(bus.fwd_size_i, fwd_offset) : '1;
    assign bus.req_data_o   = bus.fwd_wr_i ? replicate(bus.fwd_data_i, bus.fwd_size_i) : '0;
    assign bus.req_reg_id_o = tail_idx;

    // A response to a tag that is not allocated is dropped and does not return a credit.
    assign resp_hit = bus.resp_v_i & alloc_r[bus.resp_reg_id_i];
    assign deq      = bus.rev_v_o & bus.rev_ready_and_i;

    // NOTE: sequential state uses non-blocking assignment, so every update in this block reads the values from before the edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_r    <= '0;
            tail_r    <= '0;
            credits_r <= credit_width_lp'(max_credits_p);
            alloc_r   <= '0;
            valid_r   <= '0;
        end else begin
            credits_r <= credits_r + credit_width_lp'(resp_hit) - credit_width_lp'(yumi);
            if (yumi) begin
                tail_r            <= tail_r + 1'b1;
                alloc_r[tail_idx] <= 1'b1;
            end
            if (resp_hit)
                valid_r[bus.resp_reg_id_i] <= 1'b1;
            if (deq) begin
                head_r            <= head_r + 1'b1;
                alloc_r[head_idx] <= 1'b0;
                valid_r[head_idx] <= 1'b0;
            end
        end
    end

    // NOTE: the payload arrays have no reset. An entry is read only while its alloc and valid bits are set.
    always_ff @(posedge clk_i) begin
        if (yumi) begin
            hdr_mem[tail_idx]  <= bus.fwd_header_i;
            info_mem[tail_idx] <= '{offset: fwd_offset, size: bus.fwd_size_i};
        end
        if (resp_hit)
            data_mem[bus.resp_reg_id_i] <= bus.resp_data_i;
    end

    assign head_info        = info_mem[head_idx];
    assign bus.rev_v_o      = valid_r[head_idx];
    assign bus.rev_header_o = hdr_mem[head_idx];
    assign bus.rev_data_o   = replicate(data_mem[head_idx] >> {head_info.offset, 3'b000}, head_info.size);
    assign bus.idle_o       = empty;

`ifdef BP_MC_DRAM_WORD_BRIDGE_TIMEOUT_EN
    localparam int wd_width_lp = $clog2(timeout_p + 1);

    logic [wd_width_lp-1:0] wd_cnt_r;
    logic                   error_r;
    logic                   head_waiting;

    assign head_waiting = alloc_r[head_idx] & ~valid_r[head_idx];

    // The error is set on the edge where the count reaches timeout_p.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_cnt_r <= '0;
            error_r  <= 1'b0;
        end else begin
            if (deq || empty)
                wd_cnt_r <= '0;
            else if (head_waiting && wd_cnt_r != wd_width_lp'(timeout_p))
                wd_cnt_r <= wd_cnt_r + 1'b1;
            if (head_waiting && !deq && wd_cnt_r == wd_width_lp'(timeout_p - 1))
                error_r <= 1'b1;
        end
    end

    assign bus.error_o = error_r;
`else
    assign bus.error_o = 1'b0;
`endif

`ifndef SYNTHESIS
    resp_tag_allocated: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.resp_v_i |-> alloc_r[bus.resp_reg_id_i]);
`endif

endmodule

// File: tb/tb_bp_mc_dram_word_bridge.sv
// Directed bench for bp_mc_dram_word_bridge: table-driven issue-path vectors plus hand-written reorder, credit, reset and watchdog sequences.
module tb_bp_mc_dram_word_bridge;
    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    bp_mc_dram_word_bridge_if #(
        .data_width_p(32), .addr_width_p(28), .paddr_width_p(40),
        .header_width_p(64), .outstanding_p(16)
    ) b ();

    bp_mc_dram_word_bridge #(
        .data_width_p(32), .addr_width_p(28), .paddr_width_p(40), .header_width_p(64),
        .outstanding_p(16), .max_credits_p(8), .timeout_p(16)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .bus(b)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [39:0] addr;
        logic [31:0] data;
        logic [27:0] off;
        logic [27:0] exp_addr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic idle_inputs();
        b.fwd_v_i = 1'b0; b.req_ready_i = 1'b0; b.resp_v_i = 1'b0; b.rev_ready_and_i = 1'b0;
        b.fwd_header_i = '0; b.fwd_wr_i = 1'b0; b.fwd_size_i = 3'd2; b.fwd_addr_i = '0;
        b.fwd_data_i = '0; b.resp_reg_id_i = '0; b.resp_data_i = '0;
    endtask

    // Pulse reset. The outputs are checked while reset is asserted and again after release.
    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check("rst_yumi", b.fwd_yumi_o, 0);
        check("rst_req_v", b.req_v_o, 0);
        check("rst_rev_v", b.rev_v_o, 0);
        check("rst_idle", b.idle_o, 1);
        check("rst_error", b.error_o, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_idle_after", b.idle_o, 1);
        @(posedge clk); #1;
    endtask

    task automatic set_fwd(input logic [63:0] hdr, input logic wr, input logic [2:0] size,
                           input logic [39:0] addr, input logic [31:0] data);
        b.fwd_header_i = hdr; b.fwd_wr_i = wr; b.fwd_size_i = size;
        b.fwd_addr_i = addr; b.fwd_data_i = data;
    endtask

    task automatic issue(input logic [63:0] hdr, input logic wr, input logic [2:0] size,
                         input logic [39:0] addr, input logic [31:0] data, input logic [3:0] tag);
        int waited = 0;
        set_fwd(hdr, wr, size, addr, data);
        b.fwd_v_i = 1'b1; b.req_ready_i = 1'b1;
        @(negedge clk);
        while (!b.fwd_yumi_o && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check("issue_yumi", b.fwd_yumi_o, 1);
        check("issue_tag", b.req_reg_id_o, tag);
        @(posedge clk); #1;
        b.fwd_v_i = 1'b0;
    endtask

    task automatic respond(input logic [3:0] tag, input logic [31:0] data);
        b.resp_v_i = 1'b1; b.resp_reg_id_i = tag; b.resp_data_i = data;
        @(posedge clk); #1;
        b.resp_v_i = 1'b0;
    endtask

    task automatic expect_rev(input string name, input logic [63:0] hdr, input logic [31:0] data,
                              input logic chk_data);
        int waited = 0;
        b.rev_ready_and_i = 1'b1;
        @(negedge clk);
        while (!b.rev_v_o && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check({name, "_v"}, b.rev_v_o, 1);
        check({name, "_hdr"}, b.rev_header_o, hdr);
        if (chk_data) check({name, "_data"}, b.rev_data_o, data);
        @(posedge clk); #1;
        b.rev_ready_and_i = 1'b0;
    endtask

    task automatic count_issues(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (b.fwd_yumi_o) n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        //           wr  size addr             data          off          exp_addr     mask  exp_data
        vecs[0] = '{1'b1, 3'd2, 40'h100,          32'hDEADBEEF, 28'h40,      28'h80,      4'hF, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 3'd2, 40'h100,          32'h12345678, 28'h40,      28'h80,      4'hF, 32'h0};
        vecs[2] = '{1'b1, 3'd0, 40'h103,          32'h000000AB, 28'h0,       28'h40,      4'h8, 32'hABABABAB};
        vecs[3] = '{1'b1, 3'd1, 40'h206,          32'h12345678, 28'h10,      28'h91,      4'hC, 32'h56785678};
        vecs[4] = '{1'b1, 3'd0, 40'h1,            32'h000000CD, 28'h0,       28'h0,       4'h2, 32'hCDCDCDCD};
        vecs[5] = '{1'b1, 3'd3, 40'h10,           32'hCAFEF00D, 28'h0,       28'h4,       4'hF, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 3'd0, 40'hFFC,          32'hFFFFFFFF, 28'hFFFFFF0, 28'h00003EF, 4'hF, 32'h0};
        vecs[7] = '{1'b1, 3'd1, 40'h2,            32'hFFFFBEEF, 28'h1,       28'h1,       4'hC, 32'hBEEFBEEF};
        vecs[8] = '{1'b0, 3'd2, 40'h10_0000_0004, 32'h0,        28'h0,       28'h1,       4'hF, 32'h0};

        b.dram_offset_i = '0;
        do_reset();

        // Issue path alone: the beat is offered with req_ready low, so nothing is accepted.
        for (int i = 0; i < 9; i++) begin
            set_fwd(64'(i), vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].data);
            b.dram_offset_i = vecs[i].off;
            b.fwd_v_i = 1'b1; b.req_ready_i = 1'b0;
            @(negedge clk);
            check("vec_req_v", b.req_v_o, 1);
            check("vec_yumi", b.fwd_yumi_o, 0);
            check("vec_store", b.req_store_o, vecs[i].wr);
            check("vec_addr", b.req_addr_o, vecs[i].exp_addr);
            check("vec_mask", b.req_mask_o, vecs[i].exp_mask);
            check("vec_data", b.req_data_o, vecs[i].exp_data);
            @(posedge clk); #1;
        end
        b.fwd_v_i = 1'b0;
        check("vec_idle", b.idle_o, 1);

        // Store followed by a load of the same word. The two beats come back in issue order.
        b.dram_offset_i = 28'h40;
        issue(64'hA1, 1'b1, 3'd2, 40'h100, 32'hDEADBEEF, 4'd0);
        issue(64'hA2, 1'b0, 3'd2, 40'h100, 32'h0, 4'd1);
        respond(4'd1, 32'hDEADBEEF);
        @(negedge clk);
        check("ord_wait_head", b.rev_v_o, 0);
        @(posedge clk); #1;
        respond(4'd0, 32'h0);
        expect_rev("ord_store", 64'hA1, 32'h0, 1'b0);
        expect_rev("ord_load", 64'hA2, 32'hDEADBEEF, 1'b1);

        // Sub-word loads are shifted down to their byte offset, then replicated.
        issue(64'hB1, 1'b0, 3'd0, 40'h103, 32'h0, 4'd2);
        issue(64'hB2, 1'b0, 3'd1, 40'h102, 32'h0, 4'd3);
        respond(4'd3, 32'h12345678);
        respond(4'd2, 32'hAB000000);
        expect_rev("sub_byte", 64'hB1, 32'hABABABAB, 1'b1);
        expect_rev("sub_half", 64'hB2, 32'h12341234, 1'b1);
        check("sub_idle", b.idle_o, 1);

        // Out-of-order responses. rev_v_o rises the cycle after the head entry's response.
        do_reset();
        for (int i = 0; i < 4; i++)
            issue(64'hC0 + 64'(i), 1'b0, 3'd2, 40'(32'h200 + 4*i), 32'h0, 4'(i));
        respond(4'd3, 32'h33);
        respond(4'd1, 32'h11);
        @(negedge clk);
        check("ooo_head_wait", b.rev_v_o, 0);
        @(posedge clk); #1;
        b.resp_v_i = 1'b1; b.resp_reg_id_i = 4'd0; b.resp_data_i = 32'h0;
        @(negedge clk);
        check("ooo_same_cycle", b.rev_v_o, 0);
        @(posedge clk); #1;
        b.resp_v_i = 1'b0;
        @(negedge clk);
        check("ooo_next_cycle", b.rev_v_o, 1);
        @(posedge clk); #1;
        respond(4'd2, 32'h22);
        expect_rev("ooo0", 64'hC0, 32'h00, 1'b1);
        expect_rev("ooo1", 64'hC1, 32'h11, 1'b1);
        expect_rev("ooo2", 64'hC2, 32'h22, 1'b1);
        expect_rev("ooo3", 64'hC3, 32'h33, 1'b1);

        // Credit stall: eight issues, then one response lets exactly one more through.
        do_reset();
        set_fwd(64'hD0, 1'b0, 3'd2, 40'h0, 32'h0);
        b.fwd_v_i = 1'b1; b.req_ready_i = 1'b1;
        count_issues(12, n);
        check("credit_issues", 64'(n), 8);
        @(negedge clk);
        check("credit_stall_yumi", b.fwd_yumi_o, 0);
        check("credit_stall_req_v", b.req_v_o, 0);
        @(posedge clk); #1;
        respond(4'd0, 32'h0);
        count_issues(5, n);
        check("credit_one_more", 64'(n), 1);

        // Fill the buffer with the return path stalled. Issue stops at full while a credit is still free.
        b.fwd_v_i = 1'b0;
        for (int t = 1; t <= 8; t++)
            respond(4'(t), 32'h0);
        b.fwd_v_i = 1'b1;
        count_issues(10, n);
        check("full_issues", 64'(n), 7);
        @(negedge clk);
        check("full_req_v", b.req_v_o, 0);
        check("full_rev_v", b.rev_v_o, 1);
        check("full_idle", b.idle_o, 0);
        @(posedge clk); #1;
        do_reset();

        // Reset restores the full credit count.
        set_fwd(64'hE0, 1'b0, 3'd2, 40'h0, 32'h0);
        b.fwd_v_i = 1'b1; b.req_ready_i = 1'b1;
        count_issues(10, n);
        check("rst_credits", 64'(n), 8);
        do_reset();

        // Watchdog: one load that is never answered.
        issue(64'hF0, 1'b0, 3'd2, 40'h40, 32'h0, 4'd0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 15) check("wd_before", b.error_o, 0);
        end
`ifdef BP_MC_DRAM_WORD_BRIDGE_TIMEOUT_EN
        check("wd_error", b.error_o, 1);
`else
        check("wd_error", b.error_o, 0);
`endif
        respond(4'd0, 32'h5);
        expect_rev("wd_rev", 64'hF0, 32'h5, 1'b1);
`ifdef BP_MC_DRAM_WORD_BRIDGE_TIMEOUT_EN
        check("wd_sticky", b.error_o, 1);
`else
        check("wd_sticky", b.error_o, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end
endmodule
